// File: rtl/universal_shift_reg.sv
// universal_shift_reg: hold/shift-right/shift-left/load register with serial+parallel I/O and a WIDTH-shift frame counter
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);
    logic [WIDTH-1:0] q_nxt;
    logic             shifting;
    logic             last;
    always_comb begin
        q_nxt    = mode == 2'b11 ? d :
                   mode == 2'b01 ? {sin_r, q[WIDTH-1:1]} :
                   mode == 2'b10 ? {q[WIDTH-2:0], sin_l} : q;
        shifting = en & (mode[1] ^ mode[0]);
        last     = shift_cnt == CNT_W'(WIDTH - 1);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            q          <= '0;
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= shifting & last;
            if (en) q <= q_nxt;
            if (en && mode == 2'b11) shift_cnt <= '0;
            else if (shifting) shift_cnt <= last ? '0 : shift_cnt + CNT_W'(1);
        end
    end
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];
endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised universal shift register. It supersedes the fixed PIPO, SISO and SIPO register variants with a single block.
- Per-cycle mode select: hold, shift right, shift left or parallel load. Every mode supports both serial and parallel in/out.
- A shift counter tracks a frame of WIDTH shifts since the last load or reset, and pulses frame_done when the frame completes.
- Used as the common serialiser/deserialiser primitive for the datapath.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- CNT_W, 4, shift counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-low (reset==0 at a clk rising edge resets the block)
- en  input  1  clock enable; 0 = everything holds
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- sin_r  input  1  serial input entering at MSB on shift right
- sin_l  input  1  serial input entering at LSB on shift left
- d  input  WIDTH  parallel load data
- q  output  WIDTH  register contents (parallel out)
- sout_r  output  1  serial out for right shift = q[0] (combinational from q)
- sout_l  output  1  serial out for left shift = q[WIDTH-1] (combinational from q)
- shift_cnt  output  CNT_W  shifts completed in the current frame
- frame_done  output  1  one-cycle pulse after the WIDTH-th shift of a frame

Behaviour:
- Single clock domain. All state updates on the clk rising edge. No asynchronous paths.
- Priority: reset > en > mode.
- Reset (reset==0): q=0, shift_cnt=0, frame_done=0. This applies regardless of en, mode or any frame in progress.
- en==0: q and shift_cnt hold; frame_done=0.
- mode 00 (hold): q and shift_cnt hold; frame_done=0.
- mode 11 (load): q<=d, shift_cnt<=0, frame_done=0. Load aborts any partial frame; latency is 1 cycle.
- mode 01 (shift right): q<={sin_r, q[WIDTH-1:1]}.
- mode 10 (shift left): q<={q[WIDTH-2:0], sin_l}.
- Counter on each shift (01 or 10):
  - if shift_cnt==WIDTH-1: shift_cnt<=0, frame_done<=1;
  - else shift_cnt<=shift_cnt+1, frame_done<=0.
- frame_done is registered and high for exactly one cycle: the cycle following the edge that performed the WIDTH-th shift.
- Back-to-back frames: continuous shifting produces a frame_done pulse every WIDTH shifts with no gap cycle.
- Direction change mid-frame: the counter continues. Right and left shifts both count toward the same frame.
- Pause mid-frame via en=0 or mode 00: the count is preserved and the frame resumes from it.
- Serial outputs are valid in the same cycle as q. After a load, sout_r=d[0] and sout_l=d[WIDTH-1].
- Contents are shifted out, never rotated; vacated bits take the relevant sin.

Test Plan (WIDTH=8):
1. Reset: reset=0 for 2 cycles with en=1, mode=11, d=8'hA5 -> q=8'h00, shift_cnt=0, frame_done=0 throughout. Release reset -> next edge q=8'hA5.
2. Load then shift right: load 8'hA5, then mode=01, sin_r=0 for 8 cycles.
   - sout_r sequence 1,0,1,0,0,1,0,1.
   - q ends 8'h00 and shift_cnt returns to 0.
   - frame_done high exactly 1 cycle, after the 8th shift.
3. Shift left fill: from q=8'h00, mode=10, sin_l=1 for 8 cycles.
   - q=01,03,07,0F,1F,3F,7F,FF.
   - sout_l becomes 1 after the 8th edge; frame_done pulses once.
   - Continue 8 more shifts -> second frame_done pulse with no gap.
4. Pause: after 3 right shifts (shift_cnt=3), set en=0 for 4 cycles -> q and shift_cnt frozen, frame_done=0. Resume 5 shifts -> frame_done on the 5th. Repeat the pause using mode=00 -> same result.
5. Abort mid-frame:
   - After 5 shifts, load 8'h3C -> q=8'h3C, shift_cnt=0; 8 more shifts are needed for frame_done.
   - After 5 shifts, assert reset -> q=0, shift_cnt=0, no frame_done pulse.
6. Mixed direction: load 8'h81, then right, left, right, ... for 8 shifts with sin_r=sin_l=0 -> frame_done after the 8th shift; q matches the bit-accurate model at every cycle.
